alu_datamem: RTL and testbench
==============================

Name: alu_datamem

Overview:
- Combined execute/memory datapath block for the 5-stage MIPS pipeline.
- ALU-control decode (ALUOp + funct) drives a 32-bit ALU producing result and zero flag.
- The ALU result addresses a word-organised data memory: synchronous write, combinational read.
- Sits between the ID/EX and MEM/WB pipeline registers; forwarding muxes are outside this block.

Parameters:
- DMEM_WORDS, 64, number of 32-bit words in data memory (power of two).
- DMEM_AW, 6, word-index width, equal to log2(DMEM_WORDS).

Ports:
- clk  in  1  pipeline clock (cycle); all state updates on rising edge
- reset  in  1  synchronous, active-high; clears data memory
- alu_op  in  2  ALUOp from main control
- funct  in  6  instruction[5:0] (low bits of sign-extended immediate)
- src_a  in  32  ALU operand A (forwarded rs data)
- src_b  in  32  ALU operand B (forwarded rt data or immediate)
- mem_read  in  1  MemRead
- mem_write  in  1  MemWrite
- write_data  in  32  store data (forwarded rt data)
- alu_ctrl  out  4  decoded ALU control code
- alu_result  out  32  ALU result; also the memory byte address
- zero  out  1  high when alu_result == 0
- read_data  out  32  memory read data

Behaviour:
- ALU control decode, combinational:
  - alu_op 00 -> 0010 (add; lw/sw/addi)
  - alu_op 01 -> 0110 (sub; beq/bne)
  - alu_op 11 -> 0001 (or; ori)
  - alu_op 10 decodes funct: 100000 -> 0010 add; 100010 -> 0110 sub; 100100 -> 0000 and; 100101 -> 0001 or; 101010 -> 0111 slt; 100111 -> 1100 nor; any other funct -> 1111.
- ALU, combinational:
  - add/sub are 32-bit modulo; carry is discarded.
  - slt is a signed compare, result 32'd1 or 32'd0.
  - nor = ~(a|b).
  - Code 1111 or any undefined code -> result 0.
  - zero follows the result on every code.
- Data memory:
  - Word array of DMEM_WORDS entries, indexed by alu_result[DMEM_AW+1:2].
  - alu_result[1:0] is ignored (misaligned addresses round down).
  - Upper address bits are ignored, so addresses wrap modulo DMEM_WORDS*4.
- Write: on posedge clk when mem_write=1 and reset=0, mem[idx] <= write_data.
- Read: combinational. read_data = mem[idx] when mem_read=1, else 32'h0.
- Read and write to the same address in the same cycle: read_data shows the old value before the edge and the new value after it. There is no internal bypass.
- mem_read and mem_write both high: the write happens and the read shows the pre-edge contents.
- Reset:
  - Every rising edge with reset=1 clears all words to 0.
  - Reset takes priority over a simultaneous write; a store issued during reset is lost.
  - ALU outputs are purely combinational and unaffected by reset.
  - read_data shows 0 after reset completes.
- Latency: ALU 0 cycles; store visible 1 edge later; load 0 cycles (combinational).

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- When defined:
  - Extra output port overflow (1 bit) is present.
  - It is high on signed two's-complement overflow for codes 0010 and 0110, otherwise 0.
  - The result still wraps.
- When undefined: the port does not exist and there is no overflow logic.

Decomposition:
- Package alu_pkg holds:
  - ALU control code constants (AND, OR, ADD, SUB, SLT, NOR, INVALID).
  - ALUOp encodings (MEM, BRANCH, RTYPE, ORI).
  - funct constants.
- One sub-module, alu_ctrl_dec: a purely combinational alu_op/funct -> alu_ctrl decoder.
- ALU datapath and memory array live in the top.

Test Plan:
- alu_op=10, funct=100000, a=7, b=5 -> alu_ctrl=0010, result=12, zero=0. Same with funct=100010 and a=b=9 -> result 0, zero=1.
- alu_op=10, slt: a=32'hFFFFFFFF, b=1 -> result 1. Swap operands -> result 0. nor of a=0, b=0 -> 32'hFFFFFFFF.
- alu_op=10, funct=000000 -> alu_ctrl=1111, result 0, zero=1. alu_op=11, a=32'hF0, b=32'h0F -> result 32'hFF.
- Store: a=8, b=4 (add, addr 12), write_data=32'hDEADBEEF, mem_write=1, then clock edge. Next cycle load addr 12 and addr 13 (misaligned) with mem_read=1 -> DEADBEEF both times. mem_read=0 -> read_data 0.
- Wrap: store 32'h5 at byte addr 256 (DMEM_WORDS=64) -> a load from addr 0 returns 5.
- Reset with mem_write=1 at addr 12 -> word stays 0. All previously written words read 0 after reset.
- ALU_OVERFLOW_EN: a=32'h7FFFFFFF, b=1, add -> result 32'h80000000, overflow=1. a=32'h80000000, b=1, sub -> overflow=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the execute/memory datapath.
//   - ALU control codes seen on alu_ctrl
//   - ALUOp encodings driven by main control
//   - R-type funct field values decoded when ALUOp selects R-type
package alu_pkg;

    // ALU control codes
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    // ALUOp encodings
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ORI    = 2'b11;

    // R-type funct codes
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: combinational map from ALUOp + funct to ALU control code.
// Ports:
//   alu_op   in  [1:0]  ALUOp from main control
//   funct    in  [5:0]  instruction[5:0]
//   alu_ctrl out [3:0]  decoded ALU control code (ALU_INVALID for unknown funct)
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_INVALID;
        case (alu_op)
            ALUOP_MEM:    alu_ctrl = ALU_ADD;
            ALUOP_BRANCH: alu_ctrl = ALU_SUB;
            ALUOP_ORI:    alu_ctrl = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_ctrl = ALU_ADD;
                    FUNCT_SUB: alu_ctrl = ALU_SUB;
                    FUNCT_AND: alu_ctrl = ALU_AND;
                    FUNCT_OR:  alu_ctrl = ALU_OR;
                    FUNCT_SLT: alu_ctrl = ALU_SLT;
                    FUNCT_NOR: alu_ctrl = ALU_NOR;
                    default:   alu_ctrl = ALU_INVALID;
                endcase
            end
            default: alu_ctrl = ALU_INVALID;
        endcase
    end

endmodule

// File: rtl/alu_datamem.sv
// Execute/memory datapath: ALU control decode, 32-bit ALU and word-organised
// data memory addressed by the ALU result.
// Ports:
//   clk, reset             pipeline clock; synchronous active-high reset clears memory
//   alu_op, funct          ALU control inputs
//   src_a, src_b           ALU operands
//   mem_read, mem_write    memory enables
//   write_data             store data
//   alu_ctrl               decoded ALU control code
//   alu_result, zero       ALU result (also byte address) and zero flag
//   read_data              combinational load data, 0 when mem_read is low
//   overflow               signed add/sub overflow (only with ALU_OVERFLOW_EN)
// Optional feature macro: ALU_OVERFLOW_EN
module alu_datamem
    import alu_pkg::*;
#(
    parameter int DMEM_WORDS = 64,
    parameter int DMEM_AW    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] write_data,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] read_data
`ifdef ALU_OVERFLOW_EN
    ,
    output logic        overflow
`endif
);

    logic [31:0]        mem_q [DMEM_WORDS];
    logic [31:0]        mem_d [DMEM_WORDS];
    logic [DMEM_AW-1:0] idx;

    alu_ctrl_dec u_dec (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (alu_ctrl)
    );

    always_comb begin
        alu_result = 32'h0;
        case (alu_ctrl)
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_SLT: alu_result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            ALU_NOR: alu_result = ~(src_a | src_b);
            default: alu_result = 32'h0;
        endcase
    end

    assign zero = (alu_result == 32'h0);

`ifdef ALU_OVERFLOW_EN
    // Overflow when the result sign disagrees with what the operand signs imply.
    always_comb begin
        overflow = 1'b0;
        if (alu_ctrl == ALU_ADD)
            overflow = (src_a[31] == src_b[31]) && (alu_result[31] != src_a[31]);
        else if (alu_ctrl == ALU_SUB)
            overflow = (src_a[31] != src_b[31]) && (alu_result[31] != src_a[31]);
    end
`endif

    // Byte offset and upper bits are dropped: misaligned rounds down, high addresses wrap.
    assign idx = alu_result[DMEM_AW+1:2];

    assign read_data = mem_read ? mem_q[idx] : 32'h0;

    always_comb begin
        mem_d = mem_q;
        if (mem_write)
            mem_d[idx] = write_data;
    end

    // Reset wins over a concurrent store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DMEM_WORDS; i++)
                mem_q[i] <= 32'h0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_alu_datamem.sv
module tb_alu_datamem;

    localparam int WORDS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b, write_data;
    logic        mem_read, mem_write;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result, read_data;
    logic        zero;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model [WORDS];

    always #5 clk = ~clk;

    alu_datamem #(.DMEM_WORDS(WORDS), .DMEM_AW(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_op     (alu_op),
        .funct      (funct),
        .src_a      (src_a),
        .src_b      (src_b),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .write_data (write_data),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .zero       (zero),
        .read_data  (read_data)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    // Reference: what the instruction means, expressed directly from ALUOp/funct.
    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        case (f)
            6'd32:   return 4'b0010;
            6'd34:   return 4'b0110;
            6'd36:   return 4'b0000;
            6'd37:   return 4'b0001;
            6'd42:   return 4'b0111;
            6'd39:   return 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b11) return a | b;
        case (f)
            6'd32:   return a + b;
            6'd34:   return a - b;
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd42:   return (sa < sb) ? 32'd1 : 32'd0;
            6'd39:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [1:0] op, input logic [5:0] f,
                                     input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        logic is_add, is_sub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        is_add = (op == 2'b00) || (op == 2'b10 && f == 6'd32);
        is_sub = (op == 2'b01) || (op == 2'b10 && f == 6'd34);
        if (is_add) r = sa + sb;
        else if (is_sub) r = sa - sb;
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: check combinational outputs before the edge, then
    // clock and update the memory model.
    task automatic step(input logic rst, input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic rd, input logic wr, input logic [31:0] wd,
                        input string tag);
        logic [31:0] r;
        int unsigned w;
        reset = rst; alu_op = op; funct = f; src_a = a; src_b = b;
        mem_read = rd; mem_write = wr; write_data = wd;
        #2;
        r = ref_res(op, f, a, b);
        w = (r / 4) % WORDS;
        chk({tag, "_ctrl"}, {28'h0, alu_ctrl}, {28'h0, ref_ctrl(op, f)});
        chk({tag, "_res"}, alu_result, r);
        chk({tag, "_zero"}, {31'h0, zero}, {31'h0, (r == 32'h0)});
        chk({tag, "_rdata"}, read_data, rd ? model[w] : 32'h0);
`ifdef ALU_OVERFLOW_EN
        chk({tag, "_ovf"}, {31'h0, overflow}, {31'h0, ref_ovf(op, f, a, b)});
`endif
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < WORDS; i++) model[i] = 32'h0;
        end else if (wr) begin
            model[w] = wd;
        end
        #1;
    endtask

    initial begin
        logic [5:0] fl [8];
        fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0, 6'd63};
        for (int i = 0; i < WORDS; i++) model[i] = 32'h0;
        reset = 1'b1; alu_op = 2'b00; funct = 6'd0; src_a = 0; src_b = 0;
        mem_read = 1'b0; mem_write = 1'b0; write_data = 0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state: memory reads zero
        step(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0, 0, "rst_rd0");
        step(1'b0, 2'b00, 6'd0, 32'd252, 32'd0, 1'b1, 1'b0, 0, "rst_rd63");

        // ALU directed
        step(1'b0, 2'b10, 6'd32, 32'd7, 32'd5, 1'b0, 1'b0, 0, "add");
        step(1'b0, 2'b10, 6'd34, 32'd9, 32'd9, 1'b0, 1'b0, 0, "sub_zero");
        step(1'b0, 2'b10, 6'd42, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 0, "slt_neg");
        step(1'b0, 2'b10, 6'd42, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 0, "slt_swap");
        step(1'b0, 2'b10, 6'd39, 32'd0, 32'd0, 1'b0, 1'b0, 0, "nor");
        step(1'b0, 2'b10, 6'd0, 32'd3, 32'd4, 1'b0, 1'b0, 0, "invalid");
        step(1'b0, 2'b11, 6'd0, 32'hF0, 32'h0F, 1'b0, 1'b0, 0, "ori");
        step(1'b0, 2'b10, 6'd36, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 0, "and");
        step(1'b0, 2'b00, 6'd0, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 0, "add_ovf");
        step(1'b0, 2'b01, 6'd0, 32'h80000000, 32'd1, 1'b0, 1'b0, 0, "sub_ovf");

        // Store / load, misalignment, read-disable, same-cycle read+write
        step(1'b0, 2'b00, 6'd0, 32'd8, 32'd4, 1'b1, 1'b1, 32'hDEADBEEF, "st12");
        step(1'b0, 2'b00, 6'd0, 32'd8, 32'd4, 1'b1, 1'b0, 0, "ld12");
        step(1'b0, 2'b00, 6'd0, 32'd8, 32'd5, 1'b1, 1'b0, 0, "ld13");
        step(1'b0, 2'b00, 6'd0, 32'd8, 32'd4, 1'b0, 1'b0, 0, "ld12_off");
        step(1'b0, 2'b00, 6'd0, 32'd256, 32'd0, 1'b1, 1'b1, 32'h5, "st256");
        step(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0, 0, "ld0_wrap");

        // Reset beats a concurrent store; all words clear
        step(1'b1, 2'b00, 6'd0, 32'd8, 32'd4, 1'b1, 1'b1, 32'h12345678, "rst_st");
        step(1'b0, 2'b00, 6'd0, 32'd12, 32'd0, 1'b1, 1'b0, 0, "post_rst12");
        step(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0, 0, "post_rst0");

        // Randomized traffic against the model; small operands keep the
        // addresses overlapping so loads hit earlier stores.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a, b;
            logic [1:0]  op;
            logic [5:0]  f;
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom_range(0, 300);
                b = $urandom_range(0, 40);
            end else begin
                a = $urandom;
                b = $urandom;
            end
            step(($urandom_range(0, 39) == 0), op, f, a, b,
                 1'($urandom), 1'($urandom), $urandom, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
